// File: rtl/axis_line_framer_if.sv
// AXI4-Stream bundle for the line framer: pixel data, handshake, line-end and start-of-frame flags.
interface axis_line_framer_if #(
    parameter int DATA_W = 32
) ();
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic              tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_line_framer.sv
// Re-frames a disparity AXI4-Stream by pixel count into lines/frames behind a back-pressure FIFO.
// Define AXIS_LINE_FRAMER_STATS_EN to add frame_cnt and drop_cnt statistics outputs.
module axis_line_framer #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int IMG_WIDTH        = 640,
    parameter int IMG_HEIGHT       = 480,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic                aclk,
    input  logic                aresetn,
    axis_line_framer_if.slave   s_axis,
    axis_line_framer_if.master  m_axis,
    output logic                frame_done,
    output logic                overflow,
`ifdef AXIS_LINE_FRAMER_STATS_EN
    output logic                sync_err,
    output logic [31:0]         frame_cnt,
    output logic [15:0]         drop_cnt
`else
    output logic                sync_err
`endif
);
    localparam int ADDR_W  = $clog2(FIFO_DEPTH);
    localparam int PTR_W   = ADDR_W + 1;
    localparam int X_W     = $clog2(IMG_WIDTH);
    localparam int Y_W     = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int ENTRY_W = AXIS_TDATA_WIDTH + 2;
    localparam logic [X_W-1:0] X_MAX = X_W'(IMG_WIDTH - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(IMG_HEIGHT - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t               state_q, state_d;
    logic [X_W-1:0]       x_q, x_d;
    logic [Y_W-1:0]       y_q, y_d;

    logic [ENTRY_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr, count;
    logic                 full, empty, accept, drop;

    logic                 wr_en_p0, user_p0, last_p0, done_p0, err_p0;

    logic                 vld_p1, user_p1, last_p1;
    logic [AXIS_TDATA_WIDTH-1:0] data_p1;
    logic                 pop, load;
    logic [ADDR_W-1:0]    load_idx;

    assign full   = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                    (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign empty  = (wr_ptr == rd_ptr);
    assign count  = wr_ptr - rd_ptr;

    // Ready is held low while in reset so every output reads 0 then.
    assign s_axis.tready = aresetn & ~full;
    assign accept        = s_axis.tvalid & s_axis.tready;
    assign drop          = s_axis.tvalid & full;

    // ---- Stage p0: framing FSM tags each accepted beat at FIFO write ----
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        wr_en_p0 = 1'b0;
        user_p0  = 1'b0;
        last_p0  = 1'b0;
        done_p0  = 1'b0;
        err_p0   = 1'b0;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (s_axis.tuser) begin
                        wr_en_p0 = 1'b1;
                        user_p0  = 1'b1;
                        x_d      = X_W'(1);
                        y_d      = '0;
                        state_d  = ACTIVE;
                    end
                end
                ACTIVE: begin
                    wr_en_p0 = 1'b1;
                    if (s_axis.tuser) begin
                        // Restart on an early SOF; the partial frame stays queued without a tlast.
                        user_p0 = 1'b1;
                        err_p0  = (x_q != '0) || (y_q != '0) || s_axis.tlast;
                        x_d     = X_W'(1);
                        y_d     = '0;
                    end else begin
                        last_p0 = (x_q == X_MAX);
                        err_p0  = (s_axis.tlast != last_p0);
                        if (last_p0) begin
                            x_d = '0;
                            if (y_q == Y_MAX) begin
                                done_p0 = 1'b1;
                                y_d     = '0;
                                state_d = IDLE;
                            end else begin
                                y_d = y_q + Y_W'(1);
                            end
                        end else begin
                            x_d = x_q + X_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            sync_err   <= 1'b0;
            wr_ptr     <= '0;
        end else begin
            frame_done <= done_p0;
            overflow   <= overflow | drop;
            sync_err   <= sync_err | err_p0;
            wr_ptr     <= wr_ptr + PTR_W'(wr_en_p0);
        end
    end

    always_ff @(posedge aclk) begin
        if (wr_en_p0)
            mem[wr_ptr[ADDR_W-1:0]] <= {user_p0, last_p0, s_axis.tdata};
    end

    // ---- Stage p1: output register mirrors the FIFO head; entry leaves on handshake ----
    assign pop = vld_p1 & m_axis.tready;

    always_comb begin
        load     = 1'b0;
        load_idx = rd_ptr[ADDR_W-1:0];
        if (pop) begin
            load     = (count > PTR_W'(1));
            load_idx = rd_ptr[ADDR_W-1:0] + ADDR_W'(1);
        end else if (!vld_p1) begin
            load = ~empty;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_ptr  <= '0;
            vld_p1  <= 1'b0;
            user_p1 <= 1'b0;
            last_p1 <= 1'b0;
            data_p1 <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(pop);
            if (pop || !vld_p1)
                vld_p1 <= load;
            if (load)
                {user_p1, last_p1, data_p1} <= mem[load_idx];
        end
    end

    assign m_axis.tvalid = vld_p1;
    assign m_axis.tdata  = data_p1;
    assign m_axis.tlast  = last_p1;
    assign m_axis.tuser  = user_p1;

`ifdef AXIS_LINE_FRAMER_STATS_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (done_p0)
                frame_cnt <= frame_cnt + 32'd1;
            if (drop && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_line_framer.sv
// Scoreboard bench for axis_line_framer at 4x2 pixels with a 4-entry FIFO.
module tb_axis_line_framer;
    localparam int DW = 32;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int D  = 4;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    axis_line_framer_if #(.DATA_W(DW)) s_if ();
    axis_line_framer_if #(.DATA_W(DW)) m_if ();

    logic frame_done, overflow, sync_err;
`ifdef AXIS_LINE_FRAMER_STATS_EN
    logic [31:0] frame_cnt;
    logic [15:0] drop_cnt;
`endif

    axis_line_framer #(
        .AXIS_TDATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .FIFO_DEPTH(D)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .s_axis(s_if),
        .m_axis(m_if),
        .frame_done(frame_done),
        .overflow(overflow),
`ifdef AXIS_LINE_FRAMER_STATS_EN
        .sync_err(sync_err),
        .frame_cnt(frame_cnt),
        .drop_cnt(drop_cnt)
`else
        .sync_err(sync_err)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    int fd_total = 0;
    bit stop_rand = 1'b0;
    logic [DW+1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic expect_beat(input logic [DW-1:0] d, input logic u, input logic l);
        exp_q.push_back({u, l, d});
    endtask

    // Drives one beat for one cycle; called just after a rising edge.
    task automatic beat(input logic [DW-1:0] d, input logic u, input logic l, input bit wait_rdy);
        int guard = 0;
        if (wait_rdy) begin
            while (!s_if.tready && guard < 200) begin
                @(posedge aclk); #1;
                guard++;
            end
            if (guard >= 200) begin
                n_checks++;
                $display("FAIL ready_timeout: s_axis_tready stuck low for %0d cycles", guard);
            end
        end
        s_if.tdata  = d;
        s_if.tvalid = 1'b1;
        s_if.tuser  = u;
        s_if.tlast  = l;
        @(posedge aclk); #1;
        s_if.tvalid = 1'b0;
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic send_frame(input logic [DW-1:0] base, input bit wait_rdy);
        for (int i = 0; i < W * H; i++) begin
            expect_beat(base + DW'(i), (i == 0), ((i % W) == W - 1));
            beat(base + DW'(i), (i == 0), ((i % W) == W - 1), wait_rdy);
        end
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        @(posedge aclk); #1;
    endtask

    task automatic drain(input string name);
        int g = 0;
        while (exp_q.size() != 0 && g < 300) begin
            @(posedge aclk); #1;
            g++;
        end
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL %s: %0d beats still expected, required 0", name, exp_q.size());
        repeat (4) @(posedge aclk);
        #1;
    endtask

    // Monitor: samples on the falling edge, ahead of the rising edge that completes a handshake.
    initial begin
        logic [DW+1:0] e;
        forever begin
            @(negedge aclk);
            if (aresetn) begin
                if (frame_done) fd_total++;
                if (m_if.tvalid && m_if.tready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_beat: got %0h expected none",
                                 {m_if.tuser, m_if.tlast, m_if.tdata});
                    end else begin
                        e = exp_q.pop_front();
                        check("out_beat", {m_if.tuser, m_if.tlast, m_if.tdata}, e);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int fd0;
        s_if.tdata  = '0;
        s_if.tvalid = 1'b0;
        s_if.tuser  = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;

        // Test 1: async reset mid-frame, then non-SOF beats are discarded
        do_reset();
        beat(32'd50, 1'b1, 1'b0, 1'b0);
        beat(32'd51, 1'b0, 1'b1, 1'b0);
        repeat (2) @(posedge aclk);
        #1;
        check("t1_sync_err_pre", sync_err, 1);
        check("t1_tvalid_pre", m_if.tvalid, 1);
        check("t1_tdata_pre", m_if.tdata, 50);
        #3 aresetn = 1'b0;
        exp_q.delete();
        #1;
        check("t1_rst_tvalid", m_if.tvalid, 0);
        check("t1_rst_tdata", m_if.tdata, 0);
        check("t1_rst_tuser", m_if.tuser, 0);
        check("t1_rst_tlast", m_if.tlast, 0);
        check("t1_rst_tready", s_if.tready, 0);
        check("t1_rst_sync_err", sync_err, 0);
        check("t1_rst_overflow", overflow, 0);
        check("t1_rst_frame_done", frame_done, 0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        m_if.tready = 1'b1;
        @(posedge aclk); #1;
        fd0 = fd_total;
        beat(32'd60, 1'b0, 1'b0, 1'b0);
        beat(32'd61, 1'b0, 1'b1, 1'b0);
        send_frame(32'd70, 1'b0);
        drain("t1_drain");
        check("t1_frame_done", fd_total - fd0, 1);
        check("t1_sync_err", sync_err, 0);

        // Test 2: clean frame, plus first-beat latency
        do_reset();
        m_if.tready = 1'b1;
        fd0 = fd_total;
        expect_beat(32'd0, 1'b1, 1'b0);
        beat(32'd0, 1'b1, 1'b0, 1'b0);
        check("t2_latency_n", m_if.tvalid, 0);
        expect_beat(32'd1, 1'b0, 1'b0);
        beat(32'd1, 1'b0, 1'b0, 1'b0);
        check("t2_latency_n1", m_if.tvalid, 1);
        for (int i = 2; i < 8; i++) begin
            expect_beat(DW'(i), 1'b0, (i == 3 || i == 7));
            beat(DW'(i), 1'b0, (i == 3 || i == 7), 1'b0);
        end
        drain("t2_drain");
        check("t2_frame_done", fd_total - fd0, 1);
        check("t2_sync_err", sync_err, 0);
        check("t2_overflow", overflow, 0);

        // Test 3: downstream stalled, FIFO fills after 4 beats and the rest drop
        do_reset();
        m_if.tready = 1'b0;
        fd0 = fd_total;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) expect_beat(DW'(i), (i == 0), (i == 3));
            beat(DW'(i), (i == 0), (i == 3 || i == 7), 1'b0);
        end
        repeat (2) @(posedge aclk);
        #1;
        check("t3_overflow", overflow, 1);
        check("t3_tready_full", s_if.tready, 0);
        check("t3_sync_err", sync_err, 0);
`ifdef AXIS_LINE_FRAMER_STATS_EN
        check("t3_drop_cnt", drop_cnt, 4);
`endif
        m_if.tready = 1'b1;
        drain("t3_drain");
        check("t3_frame_done", fd_total - fd0, 0);
        check("t3_overflow_sticky", overflow, 1);

        // Test 4: early tuser on beat 2 restarts the frame
        do_reset();
        m_if.tready = 1'b1;
        fd0 = fd_total;
        expect_beat(32'd0, 1'b1, 1'b0); beat(32'd0, 1'b1, 1'b0, 1'b0);
        expect_beat(32'd1, 1'b0, 1'b0); beat(32'd1, 1'b0, 1'b0, 1'b0);
        expect_beat(32'd2, 1'b1, 1'b0); beat(32'd2, 1'b1, 1'b0, 1'b0);
        expect_beat(32'd3, 1'b0, 1'b0); beat(32'd3, 1'b0, 1'b0, 1'b0);
        expect_beat(32'd4, 1'b0, 1'b0); beat(32'd4, 1'b0, 1'b0, 1'b0);
        expect_beat(32'd5, 1'b0, 1'b1); beat(32'd5, 1'b0, 1'b1, 1'b0);
        for (int i = 6; i < 10; i++) begin
            expect_beat(DW'(i), 1'b0, (i == 9));
            beat(DW'(i), 1'b0, (i == 9), 1'b0);
        end
        drain("t4_drain");
        check("t4_sync_err", sync_err, 1);
        check("t4_frame_done", fd_total - fd0, 1);

        // Test 5: upstream tlast one beat early; regenerated tlast stays on beat 3
        do_reset();
        m_if.tready = 1'b1;
        fd0 = fd_total;
        for (int i = 0; i < 8; i++) begin
            expect_beat(DW'(i), (i == 0), (i == 3 || i == 7));
            beat(DW'(i), (i == 0), (i == 2 || i == 7), 1'b0);
        end
        drain("t5_drain");
        check("t5_sync_err", sync_err, 1);
        check("t5_frame_done", fd_total - fd0, 1);

        // Test 6: random downstream ready, three back-to-back frames
        do_reset();
        fd0 = fd_total;
        stop_rand = 1'b0;
        fork
            begin
                while (!stop_rand) begin
                    m_if.tready = 1'($urandom_range(0, 1));
                    @(posedge aclk); #1;
                end
            end
        join_none
        send_frame(32'h100, 1'b1);
        send_frame(32'h200, 1'b1);
        send_frame(32'h300, 1'b1);
        stop_rand = 1'b1;
        @(posedge aclk); #1;
        m_if.tready = 1'b1;
        drain("t6_drain");
        check("t6_frame_done", fd_total - fd0, 3);
        check("t6_overflow", overflow, 0);
        check("t6_sync_err", sync_err, 0);
`ifdef AXIS_LINE_FRAMER_STATS_EN
        check("t6_frame_cnt", frame_cnt, 3);
        check("t6_drop_cnt", drop_cnt, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
